// File: rtl/rr_arb_pkg.sv
// rr_arb_pkg: shared types and constants for the round-robin grant arbiter.
//   arb_state_t   : arbiter FSM state (IDLE, GRANT)
//   RR_DEFAULT_N  : default requester count
//   BURST_CNT_W   : width of the optional burst counter
package rr_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_t;

   localparam int RR_DEFAULT_N = 8;
   localparam int BURST_CNT_W  = 8;

endpackage

// File: rtl/prio_enc_n.sv
// prio_enc_n: N-to-IDW priority encoder, highest set index wins.
// Ports:
//   vec : input vector to search
//   idx : binary index of the highest set bit (0 when vec is empty)
//   vld : high when any bit of vec is set
module prio_enc_n
   import rr_arb_pkg::*;
#(
   parameter  int N   = RR_DEFAULT_N,
   localparam int IDW = $clog2(N)
) (
   input  logic [N-1:0]   vec,
   output logic [IDW-1:0] idx,
   output logic           vld
);

   // Ascending scan: the last set bit seen is the highest index.
   always_comb begin
      idx = '0;
      vld = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (vec[i]) begin
            idx = IDW'(i);
            vld = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rr_grant_arbiter.sv
// rr_grant_arbiter: registered round-robin arbiter, N requesters, one owner.
// The owner keeps the grant until it drops its request. Re-arbitration uses a
// masked search (indices below the last owner first, highest index wins),
// falling back to the full request set.
// Optional feature macro: RR_GRANT_ARBITER_BURST_LIMIT_EN
//   When defined, an owner is forced to rotate out after MAX_BURST
//   consecutive grant cycles if anyone else is requesting.
// Ports:
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset
//   req       : level-sensitive request vector
//   gnt       : registered one-hot grant, zero when idle
//   gnt_id    : registered binary owner index, zero when idle
//   gnt_valid : high while a grant is active (|gnt)
module rr_grant_arbiter
   import rr_arb_pkg::*;
#(
   parameter  int N         = RR_DEFAULT_N,
   parameter  int MAX_BURST = 4,
   localparam int IDW       = $clog2(N)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [N-1:0]   req,
   output logic [N-1:0]   gnt,
   output logic [IDW-1:0] gnt_id,
   output logic           gnt_valid
);

   arb_state_t     state_q, state_d;
   logic [IDW-1:0] ptr_q, ptr_d;
   logic [N-1:0]   gnt_q, gnt_d;
   logic [IDW-1:0] gnt_id_q, gnt_id_d;

   logic [N-1:0]   srch_vec;
   logic [N-1:0]   low_mask;
   logic [IDW-1:0] m_idx, f_idx, win_idx;
   logic           m_vld, f_vld;
   logic           owner_req;
   logic           rearb;
   logic           go_idle;

   // The current owner is always excluded from the search; in IDLE gnt_q is
   // zero so this is the plain request vector.
   assign srch_vec  = req & ~gnt_q;
   assign owner_req = |(req & gnt_q);

   always_comb begin
      low_mask = '0;
      for (int i = 0; i < N; i++) begin
         low_mask[i] = (i < int'(ptr_q));
      end
   end

   prio_enc_n #(.N(N)) u_enc_masked (
      .vec (srch_vec & low_mask),
      .idx (m_idx),
      .vld (m_vld)
   );

   prio_enc_n #(.N(N)) u_enc_full (
      .vec (srch_vec),
      .idx (f_idx),
      .vld (f_vld)
   );

   // The full set is a superset of the masked set, so f_vld covers both.
   assign win_idx = m_vld ? m_idx : f_idx;

`ifdef RR_GRANT_ARBITER_BURST_LIMIT_EN
   logic [BURST_CNT_W-1:0] burst_cnt_q, burst_cnt_d;
   logic                   burst_max;

   assign burst_max = (burst_cnt_q == BURST_CNT_W'(MAX_BURST));
`else
   localparam int unused_max_burst = MAX_BURST;
`endif

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      gnt_d    = gnt_q;
      gnt_id_d = gnt_id_q;
      rearb    = 1'b0;
      go_idle  = 1'b0;

      unique case (state_q)
         IDLE: begin
            rearb = f_vld;
         end
         GRANT: begin
            if (!owner_req) begin
               if (f_vld) begin
                  rearb = 1'b1;
               end else begin
                  go_idle = 1'b1;
               end
            end
`ifdef RR_GRANT_ARBITER_BURST_LIMIT_EN
            // Burst exhausted and someone else is waiting: force rotation.
            else if (burst_max && f_vld) begin
               rearb = 1'b1;
            end
`endif
         end
         default: begin
            go_idle = 1'b1;
         end
      endcase

      if (rearb) begin
         gnt_d          = '0;
         gnt_d[win_idx] = 1'b1;
         gnt_id_d       = win_idx;
         ptr_d          = win_idx;
         state_d        = GRANT;
      end else if (go_idle) begin
         // ptr keeps the last owner so the next search starts below it.
         gnt_d    = '0;
         gnt_id_d = '0;
         state_d  = IDLE;
      end
   end

`ifdef RR_GRANT_ARBITER_BURST_LIMIT_EN
   // Loads 1 on each new grant, counts held cycles, saturates at MAX_BURST.
   always_comb begin
      burst_cnt_d = burst_cnt_q;
      if (rearb) begin
         burst_cnt_d = BURST_CNT_W'(1);
      end else if (go_idle) begin
         burst_cnt_d = '0;
      end else if ((state_q == GRANT) && !burst_max) begin
         burst_cnt_d = burst_cnt_q + BURST_CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         burst_cnt_q <= '0;
      end else begin
         burst_cnt_q <= burst_cnt_d;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         ptr_q    <= '0;
         gnt_q    <= '0;
         gnt_id_q <= '0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         gnt_q    <= gnt_d;
         gnt_id_q <= gnt_id_d;
      end
   end

   assign gnt       = gnt_q;
   assign gnt_id    = gnt_id_q;
   assign gnt_valid = |gnt_q;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
module tb_rr_grant_arbiter;

   localparam int N = 8;

   typedef struct {
      logic       rst;
      logic [7:0] req;
      logic [2:0] id;
      logic       v;
   } vec_t;

   typedef struct {
      logic [2:0] id;
      logic       v;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] req;
   logic [7:0] gnt;
   logic [2:0] gnt_id;
   logic       gnt_valid;

   int checks   = 0;
   int failures = 0;

   vec_t tbl [33];
   exp_t sb_q [$];

   rr_grant_arbiter #(.N(N), .MAX_BURST(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .gnt       (gnt),
      .gnt_id    (gnt_id),
      .gnt_valid (gnt_valid)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int step, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s step=%0d actual=0x%0h required=0x%0h", name, step, act, exp);
      end
   endtask

   // Drive one cycle of stimulus, queue the expected result, then compare
   // after the edge that samples it.
   task automatic apply(input string name, input int step, input logic r,
                        input logic [7:0] rq, input logic [2:0] eid, input logic ev);
      exp_t e;
      exp_t got;
      logic [7:0] egnt;
      rst = r;
      req = rq;
      e.id = eid;
      e.v  = ev;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL %s step=%0d scoreboard empty", name, step);
      end else begin
         got  = sb_q.pop_front();
         egnt = got.v ? (8'h01 << got.id) : 8'h00;
         check({name, "_valid"}, step, 32'(gnt_valid), 32'(got.v));
         check({name, "_id"},    step, 32'(gnt_id),    32'(got.v ? got.id : 3'd0));
         check({name, "_gnt"},   step, 32'(gnt),       32'(egnt));
      end
   endtask

   initial begin
      rst = 1'b1;
      req = 8'h00;

      // Reset and fixed-priority first grant, no-bubble handover.
      tbl[0]  = '{1'b1, 8'h00, 3'd0, 1'b0};
      tbl[1]  = '{1'b1, 8'h81, 3'd0, 1'b0};
      tbl[2]  = '{1'b0, 8'h81, 3'd7, 1'b1};
      tbl[3]  = '{1'b0, 8'h81, 3'd7, 1'b1};
      tbl[4]  = '{1'b0, 8'h01, 3'd0, 1'b1};
      tbl[5]  = '{1'b0, 8'h01, 3'd0, 1'b1};
      tbl[6]  = '{1'b0, 8'h00, 3'd0, 1'b0};
      // Full rotation 7..0 then wrap to 7.
      tbl[7]  = '{1'b0, 8'hFF, 3'd7, 1'b1};
      tbl[8]  = '{1'b0, 8'h7F, 3'd6, 1'b1};
      tbl[9]  = '{1'b0, 8'hBF, 3'd5, 1'b1};
      tbl[10] = '{1'b0, 8'hDF, 3'd4, 1'b1};
      tbl[11] = '{1'b0, 8'hEF, 3'd3, 1'b1};
      tbl[12] = '{1'b0, 8'hF7, 3'd2, 1'b1};
      tbl[13] = '{1'b0, 8'hFB, 3'd1, 1'b1};
      tbl[14] = '{1'b0, 8'hFD, 3'd0, 1'b1};
      tbl[15] = '{1'b0, 8'hFE, 3'd7, 1'b1};
      tbl[16] = '{1'b0, 8'h00, 3'd0, 1'b0};
      // Owner 3 alone releases; full-set fallback picks 4.
      tbl[17] = '{1'b0, 8'h08, 3'd3, 1'b1};
      tbl[18] = '{1'b0, 8'h08, 3'd3, 1'b1};
      tbl[19] = '{1'b0, 8'h00, 3'd0, 1'b0};
      tbl[20] = '{1'b0, 8'h18, 3'd4, 1'b1};
      tbl[21] = '{1'b0, 8'h18, 3'd4, 1'b1};
      // New requesters appearing do not disturb the owner.
      tbl[22] = '{1'b0, 8'h1F, 3'd4, 1'b1};
      tbl[23] = '{1'b0, 8'h0F, 3'd3, 1'b1};
      // Reset mid-grant, then fresh fixed-priority grant.
      tbl[24] = '{1'b0, 8'h20, 3'd5, 1'b1};
      tbl[25] = '{1'b0, 8'h20, 3'd5, 1'b1};
      tbl[26] = '{1'b1, 8'h20, 3'd0, 1'b0};
      tbl[27] = '{1'b0, 8'h24, 3'd5, 1'b1};
      tbl[28] = '{1'b0, 8'h24, 3'd5, 1'b1};
      tbl[29] = '{1'b0, 8'h04, 3'd2, 1'b1};
      tbl[30] = '{1'b0, 8'h00, 3'd0, 1'b0};
      // Sole requester is regranted.
      tbl[31] = '{1'b0, 8'h04, 3'd2, 1'b1};
      tbl[32] = '{1'b0, 8'h00, 3'd0, 1'b0};

      @(posedge clk);
      #1;
      for (int i = 0; i < 33; i++) begin
         apply("tbl", i, tbl[i].rst, tbl[i].req, tbl[i].id, tbl[i].v);
      end

      // Two requesters held constant from reset.
      apply("hold88_rst", 0, 1'b1, 8'h00, 3'd0, 1'b0);
      for (int k = 0; k < 16; k++) begin
`ifdef RR_GRANT_ARBITER_BURST_LIMIT_EN
         apply("hold88", k, 1'b0, 8'h88, (((k / 4) % 2) == 0) ? 3'd7 : 3'd3, 1'b1);
`else
         apply("hold88", k, 1'b0, 8'h88, 3'd7, 1'b1);
`endif
      end

      // A lone requester keeps the grant indefinitely.
      apply("hold40_rst", 0, 1'b1, 8'h00, 3'd0, 1'b0);
      for (int k = 0; k < 10; k++) begin
         apply("hold40", k, 1'b0, 8'h40, 3'd6, 1'b1);
      end
      apply("hold40_rel", 0, 1'b0, 8'h00, 3'd0, 1'b0);

      if (sb_q.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL scoreboard_leftover actual=%0d required=0", sb_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
